// File: rtl/mp_cache_tag_bank.sv
// Parametrised single-port cache tag store with valid bits, lane write mask, invalidate and self-timed flush.
// Optional build macro MP_CACHE_TAG_FWD_EN forwards the pending write onto the read port.
module mp_cache_tag_bank #(
    parameter int DATA_WIDTH  = 24,
    parameter int ADDR_WIDTH  = 4,
    parameter int WMASK_WIDTH = 3
) (
    input  logic                   clk0,
    input  logic                   rst0_n,
    input  logic                   csb0,
    input  logic                   web0,
    input  logic                   inv0,
    input  logic [WMASK_WIDTH-1:0] wmask0,
    input  logic [ADDR_WIDTH-1:0]  addr0,
    input  logic [DATA_WIDTH-1:0]  din0,
    input  logic                   flush0,
    output logic [DATA_WIDTH-1:0]  dout0,
    output logic                   valid0,
    output logic                   busy0
);

    localparam int RAM_DEPTH  = 1 << ADDR_WIDTH;
    localparam int LANE_WIDTH = DATA_WIDTH / WMASK_WIDTH;

    typedef enum logic {IDLE, SWEEP} state_t;

    state_t                  state, state_next;
    logic [ADDR_WIDTH-1:0]   cnt, cnt_next;

    logic [ADDR_WIDTH-1:0]   addr0_reg;
    logic [DATA_WIDTH-1:0]   din0_reg;
    logic [WMASK_WIDTH-1:0]  wmask0_reg;
    logic                    web0_reg;
    logic                    inv0_reg;

    logic [DATA_WIDTH-1:0]   mem [RAM_DEPTH];
    logic [RAM_DEPTH-1:0]    vld;

    logic                    accept;
    logic                    write_en;
    logic [DATA_WIDTH-1:0]   rd_data;
    logic                    rd_valid;

    assign busy0    = (state == SWEEP);
    assign accept   = ~csb0 & ~busy0 & ~flush0;
    assign write_en = ~web0_reg & ~inv0_reg;

    // NOTE: reset puts the FSM in SWEEP so the array is zeroed without any reset on mem itself.
    always_ff @(posedge clk0 or negedge rst0_n) begin
        if (!rst0_n) begin
            state <= SWEEP;
            cnt   <= '0;
        end else begin
            state <= state_next;
            cnt   <= cnt_next;
        end
    end

    // NOTE: defaults first so every path assigns both outputs and no latch is inferred.
    always_comb begin
        state_next = state;
        cnt_next   = cnt;
        case (state)
            IDLE: begin
                if (flush0) state_next = SWEEP;
            end
            SWEEP: begin
                cnt_next = cnt + 1'b1;
                if (&cnt) state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    // Web/inv drop back to idle whenever nothing is accepted, so a write never repeats.
    always_ff @(posedge clk0 or negedge rst0_n) begin
        if (!rst0_n) begin
            addr0_reg  <= '0;
            din0_reg   <= '0;
            wmask0_reg <= '0;
            web0_reg   <= 1'b1;
            inv0_reg   <= 1'b0;
        end else if (accept) begin
            addr0_reg  <= addr0;
            din0_reg   <= din0;
            wmask0_reg <= wmask0;
            web0_reg   <= web0;
            inv0_reg   <= inv0;
        end else begin
            web0_reg   <= 1'b1;
            inv0_reg   <= 1'b0;
        end
    end

    // NOTE: the data array is deliberately not reset; the sweep clears it after reset instead.
    always_ff @(posedge clk0) begin
        if (state == SWEEP) begin
            mem[cnt] <= '0;
        end else if (write_en) begin
            for (int i = 0; i < WMASK_WIDTH; i++) begin
                if (wmask0_reg[i])
                    mem[addr0_reg][i*LANE_WIDTH +: LANE_WIDTH] <= din0_reg[i*LANE_WIDTH +: LANE_WIDTH];
            end
        end
    end

    // A write sets valid even with an all-zero mask; invalidate leaves the data alone.
    always_ff @(posedge clk0 or negedge rst0_n) begin
        if (!rst0_n) begin
            vld <= '0;
        end else if (state == SWEEP) begin
            vld[cnt] <= 1'b0;
        end else if (inv0_reg) begin
            vld[addr0_reg] <= 1'b0;
        end else if (!web0_reg) begin
            vld[addr0_reg] <= 1'b1;
        end
    end

    always_comb begin
        rd_data  = mem[addr0_reg];
        rd_valid = vld[addr0_reg];
`ifdef MP_CACHE_TAG_FWD_EN
        if (inv0_reg) begin
            rd_valid = 1'b0;
        end else if (!web0_reg) begin
            for (int i = 0; i < WMASK_WIDTH; i++) begin
                if (wmask0_reg[i])
                    rd_data[i*LANE_WIDTH +: LANE_WIDTH] = din0_reg[i*LANE_WIDTH +: LANE_WIDTH];
            end
            rd_valid = 1'b1;
        end
`else
        // The pending cycle shows the array contents as they were before the write lands.
`endif
    end

    assign dout0  = busy0 ? '0 : rd_data;
    assign valid0 = busy0 ? 1'b0 : rd_valid;

endmodule

// File: tb/tb_mp_cache_tag_bank.sv
// Scoreboard bench for mp_cache_tag_bank: a reference model predicts each read slot, a monitor compares it.
`timescale 1ns/1ps
module tb_mp_cache_tag_bank;

    logic        clk0 = 1'b0;
    logic        rst0_n;
    logic        csb0, web0, inv0, flush0;
    logic [2:0]  wmask0;
    logic [3:0]  addr0;
    logic [23:0] din0;
    logic [23:0] dout0;
    logic        valid0, busy0;

    int n_checks = 0;
    int n_pass   = 0;

    logic [23:0] m_mem [16];
    logic        m_vld [16];

    logic [23:0] exp_d [$];
    logic        exp_v [$];
    logic [3:0]  exp_a [$];
    bit          issued   = 1'b0;
    bit          issued_q = 1'b0;

    mp_cache_tag_bank dut (
        .clk0   (clk0),
        .rst0_n (rst0_n),
        .csb0   (csb0),
        .web0   (web0),
        .inv0   (inv0),
        .wmask0 (wmask0),
        .addr0  (addr0),
        .din0   (din0),
        .flush0 (flush0),
        .dout0  (dout0),
        .valid0 (valid0),
        .busy0  (busy0)
    );

    always #5 clk0 = ~clk0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    // The read slot of a request accepted at one posedge is observed at the following negedge.
    always @(posedge clk0) issued_q <= issued;

    always @(negedge clk0) begin
        if (issued_q) begin
            if (exp_d.size() == 0) begin
                check("sb_underflow", exp_d.size(), 1);
            end else begin
                logic [23:0] ed;
                logic        ev;
                logic [3:0]  ea;
                ed = exp_d.pop_front();
                ev = exp_v.pop_front();
                ea = exp_a.pop_front();
                check($sformatf("rd%0d_dout", ea), dout0, ed);
                check($sformatf("rd%0d_valid", ea), valid0, ev);
            end
        end
    end

    task automatic clear_model();
        for (int i = 0; i < 16; i++) begin
            m_mem[i] = '0;
            m_vld[i] = 1'b0;
        end
    endtask

    task automatic req(input logic [3:0] a, input logic w, input logic i,
                       input logic [2:0] m, input logic [23:0] d);
        logic [23:0] merged, ed;
        logic        ev;
        @(negedge clk0);
        csb0 = 1'b0; web0 = w; inv0 = i; wmask0 = m; addr0 = a; din0 = d;
        merged = m_mem[a];
        for (int k = 0; k < 3; k++)
            if (m[k]) merged[k*8 +: 8] = d[k*8 +: 8];
        ed = m_mem[a];
        ev = m_vld[a];
`ifdef MP_CACHE_TAG_FWD_EN
        if (i) ev = 1'b0;
        else if (!w) begin ed = merged; ev = 1'b1; end
`endif
        exp_d.push_back(ed);
        exp_v.push_back(ev);
        exp_a.push_back(a);
        issued = 1'b1;
        if (i) m_vld[a] = 1'b0;
        else if (!w) begin m_mem[a] = merged; m_vld[a] = 1'b1; end
    endtask

    task automatic rd(input logic [3:0] a);
        req(a, 1'b1, 1'b0, 3'b000, 24'h0);
    endtask

    task automatic idle();
        @(negedge clk0);
        csb0 = 1'b1; web0 = 1'b1; inv0 = 1'b0; issued = 1'b0;
    endtask

    // Raises flush0 for one edge, optionally alongside a write that must be dropped.
    task automatic start_flush(input bit with_write);
        @(negedge clk0);
        flush0 = 1'b1;
        issued = 1'b0;
        if (with_write) begin
            csb0 = 1'b0; web0 = 1'b0; inv0 = 1'b0; wmask0 = 3'b111;
            addr0 = 4'd1; din0 = 24'hAAAAAA;
        end else begin
            csb0 = 1'b1; web0 = 1'b1;
        end
        @(posedge clk0);
        #1;
        flush0 = 1'b0; csb0 = 1'b1; web0 = 1'b1;
        check("flush_busy_rise", busy0, 1'b1);
        clear_model();
    endtask

    // Counts posedges until busy0 falls; optionally re-pulses flush0 mid-sweep.
    task automatic wait_sweep(input string tag, input int pulse_at);
        int n = 0;
        while (busy0 && n < 64) begin
            if (n == pulse_at) flush0 = 1'b1;
            @(posedge clk0);
            #1;
            flush0 = 1'b0;
            n++;
        end
        check(tag, n, 16);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        rst0_n = 1'b0; csb0 = 1'b1; web0 = 1'b1; inv0 = 1'b0; flush0 = 1'b0;
        wmask0 = '0; addr0 = '0; din0 = '0;
        clear_model();

        repeat (3) @(negedge clk0);
        check("rst_busy", busy0, 1'b1);
        check("rst_dout", dout0, 24'h0);
        check("rst_valid", valid0, 1'b0);
        rst0_n = 1'b1;
        wait_sweep("reset_sweep_len", -1);

        for (int i = 0; i < 16; i++) rd(4'(i));

        req(4'd5, 1'b0, 1'b0, 3'b111, 24'hABCDEF);
        req(4'd5, 1'b0, 1'b0, 3'b010, 24'h123456);
        rd(4'd5);
        req(4'd6, 1'b0, 1'b0, 3'b000, 24'hFFFFFF);
        rd(4'd6);

        req(4'd2, 1'b0, 1'b0, 3'b111, 24'h00FF00);
        req(4'd2, 1'b1, 1'b1, 3'b000, 24'h0);
        rd(4'd2);

        req(4'd3, 1'b0, 1'b0, 3'b111, 24'h111111);
        rd(4'd3);
        rd(4'd3);
        idle();
        rd(4'd5);
        idle();
        idle();

        // Write to 7 just before the flush; the sweep must overwrite it.
        req(4'd7, 1'b0, 1'b0, 3'b111, 24'h777777);
        start_flush(1'b1);
        wait_sweep("flush_sweep_len", 5);
        rd(4'd1);
        rd(4'd7);
        rd(4'd5);
        idle();

        start_flush(1'b0);
        repeat (9) @(posedge clk0);
        #1;
        rst0_n = 1'b0;
        #1;
        check("rst_mid_busy", busy0, 1'b1);
        clear_model();
        repeat (2) @(negedge clk0);
        rst0_n = 1'b1;
        wait_sweep("rst_mid_sweep_len", -1);
        rd(4'd9);
        rd(4'd2);
        idle();
        idle();

        check("sb_drained", exp_d.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
